color_blob_tracker: RTL and testbench

- Consumes the raster RGB pixel stream (VGA_R/G/B + valid) produced by the pixel-source stage.
- Classifies each pixel against a colour threshold and accumulates the per-frame bounding box and match count of the tracked object (the player's paddle marker).
- Publishes one registered result set per frame to the pong game logic, with a one-cycle frame_done strobe.

---
 rtl/color_blob_if.sv | 11 +
 rtl/color_blob_tracker.sv | 127 ++++++++++++
 tb/tb_color_blob_tracker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/color_blob_if.sv
// Pixel stream carrying one RGB sample per cycle from the pixel source to the blob tracker.
// Valid-only stream: the sink has no backpressure, so every cycle with valid=1 delivers exactly one pixel.
interface color_blob_if;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       valid;

    modport master (output VGA_R, VGA_G, VGA_B, valid);
    modport slave  (input  VGA_R, VGA_G, VGA_B, valid);
endinterface

// File: rtl/color_blob_tracker.sv
// Classifies raster pixels against a red threshold and publishes the per-frame bounding box,
// centre and match count of the tracked marker, with a one-cycle frame_done strobe.
module color_blob_tracker #(
    parameter int         WIDTH     = 640,
    parameter int         HEIGHT    = 480,
    parameter int         X_WIDTH   = 10,
    parameter int         Y_WIDTH   = 9,
    parameter int         CNT_WIDTH = 19,
    parameter logic [7:0] R_MIN     = 8'd160,
    parameter logic [7:0] G_MAX     = 8'd80,
    parameter logic [7:0] B_MAX     = 8'd80,
    parameter int         MIN_COUNT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    color_blob_if.slave          pix,
    output logic                 mask,
    output logic                 mask_valid,
    output logic [X_WIDTH-1:0]   x_min,
    output logic [X_WIDTH-1:0]   x_max,
    output logic [Y_WIDTH-1:0]   y_min,
    output logic [Y_WIDTH-1:0]   y_max,
    output logic [X_WIDTH-1:0]   x_center,
    output logic [Y_WIDTH-1:0]   y_center,
    output logic [CNT_WIDTH-1:0] pix_count,
    output logic                 obj_found,
    output logic                 frame_done
);

    localparam logic [X_WIDTH-1:0]   X_LAST  = X_WIDTH'(WIDTH - 1);
    localparam logic [Y_WIDTH-1:0]   Y_LAST  = Y_WIDTH'(HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_COUNT);

    logic [X_WIDTH-1:0]   r_x;
    logic [Y_WIDTH-1:0]   r_y;
    logic [X_WIDTH-1:0]   r_acc_xmin;
    logic [X_WIDTH-1:0]   r_acc_xmax;
    logic [Y_WIDTH-1:0]   r_acc_ymin;
    logic [Y_WIDTH-1:0]   r_acc_ymax;
    logic [CNT_WIDTH-1:0] r_acc_cnt;

    logic                 w_match;
    logic                 w_x_last;
    logic                 w_eof;
    logic [X_WIDTH-1:0]   w_xmin_n;
    logic [X_WIDTH-1:0]   w_xmax_n;
    logic [Y_WIDTH-1:0]   w_ymin_n;
    logic [Y_WIDTH-1:0]   w_ymax_n;
    logic [CNT_WIDTH-1:0] w_cnt_n;
    logic                 w_found;
    logic [X_WIDTH:0]     w_xsum;
    logic [Y_WIDTH:0]     w_ysum;

    assign w_match  = pix.valid && (pix.VGA_R >= R_MIN) && (pix.VGA_G <= G_MAX) && (pix.VGA_B <= B_MAX);
    assign w_x_last = (r_x == X_LAST);
    assign w_eof    = pix.valid && w_x_last && (r_y == Y_LAST);

    // Accumulator values including the current pixel, so the end-of-frame pixel is published too.
    assign w_xmin_n = (w_match && (r_x < r_acc_xmin)) ? r_x : r_acc_xmin;
    assign w_xmax_n = (w_match && (r_x > r_acc_xmax)) ? r_x : r_acc_xmax;
    assign w_ymin_n = (w_match && (r_y < r_acc_ymin)) ? r_y : r_acc_ymin;
    assign w_ymax_n = (w_match && (r_y > r_acc_ymax)) ? r_y : r_acc_ymax;
    assign w_cnt_n  = r_acc_cnt + CNT_WIDTH'(w_match);
    assign w_found  = (w_cnt_n >= MIN_CNT);
    assign w_xsum   = {1'b0, w_xmin_n} + {1'b0, w_xmax_n};
    assign w_ysum   = {1'b0, w_ymin_n} + {1'b0, w_ymax_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_acc_xmin <= '1;
            r_acc_xmax <= '0;
            r_acc_ymin <= '1;
            r_acc_ymax <= '0;
            r_acc_cnt  <= '0;
            mask       <= 1'b0;
            mask_valid <= 1'b0;
            frame_done <= 1'b0;
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            x_center   <= '0;
            y_center   <= '0;
            pix_count  <= '0;
            obj_found  <= 1'b0;
        end else begin
            mask       <= w_match;
            mask_valid <= pix.valid;
            frame_done <= w_eof;
            if (pix.valid) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                if (w_eof) begin
                    pix_count <= w_cnt_n;
                    obj_found <= w_found;
                    // Box and centre hold across sparse frames, which also keeps sentinels unpublished.
                    if (w_found) begin
                        x_min    <= w_xmin_n;
                        x_max    <= w_xmax_n;
                        y_min    <= w_ymin_n;
                        y_max    <= w_ymax_n;
                        x_center <= w_xsum[X_WIDTH:1];
                        y_center <= w_ysum[Y_WIDTH:1];
                    end
                    r_acc_xmin <= '1;
                    r_acc_xmax <= '0;
                    r_acc_ymin <= '1;
                    r_acc_ymax <= '0;
                    r_acc_cnt  <= '0;
                end else begin
                    r_acc_xmin <= w_xmin_n;
                    r_acc_xmax <= w_xmax_n;
                    r_acc_ymin <= w_ymin_n;
                    r_acc_ymax <= w_ymax_n;
                    r_acc_cnt  <= w_cnt_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Directed bench for color_blob_tracker on an 8x4 raster with MIN_COUNT=2.
module tb_color_blob_tracker;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int CW = 6;

    logic          clk;
    logic          reset_n;
    logic          mask;
    logic          mask_valid;
    logic [XW-1:0] x_min, x_max, x_center;
    logic [YW-1:0] y_min, y_max, y_center;
    logic [CW-1:0] pix_count;
    logic          obj_found;
    logic          frame_done;

    int n_vec;
    int n_err;
    int done_cnt;

    color_blob_if pix_if ();

    color_blob_tracker #(
        .WIDTH(W), .HEIGHT(H), .X_WIDTH(XW), .Y_WIDTH(YW), .CNT_WIDTH(CW),
        .R_MIN(8'd160), .G_MAX(8'd80), .B_MAX(8'd80), .MIN_COUNT(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix        (pix_if.slave),
        .mask       (mask),
        .mask_valid (mask_valid),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .x_center   (x_center),
        .y_center   (y_center),
        .pix_count  (pix_count),
        .obj_found  (obj_found),
        .frame_done (frame_done)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // frame_done pulse counter, sampled 2ns after each rising edge
    always @(posedge clk) begin
        #2;
        if (reset_n && frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; registered outputs seen here reflect the previous pixel.
    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic v);
        @(negedge clk);
        pix_if.VGA_R = r;
        pix_if.VGA_G = g;
        pix_if.VGA_B = b;
        pix_if.valid = v;
    endtask

    // kind 0: black, 1: block x=2..4 y=1..2, 2: single (7,3), 3: block plus (7,3)
    function automatic bit is_red(input int kind, input int x, input int y);
        bit blk;
        blk = (x >= 2 && x <= 4 && y >= 1 && y <= 2);
        case (kind)
            1:       return blk;
            2:       return (x == 7 && y == 3);
            3:       return blk || (x == 7 && y == 3);
            default: return 1'b0;
        endcase
    endfunction

    // Drives raster pixels start..W*H-1; with gaps a red invalid cycle follows each pixel.
    task automatic send_frame(input int kind, input bit gaps, input int start);
        for (int i = start; i < W * H; i++) begin
            if (is_red(kind, i % W, i / W)) drive(8'd200, 8'd10, 8'd10, 1'b1);
            else                            drive(8'd0, 8'd0, 8'd0, 1'b1);
            if (gaps && i != W * H - 1) drive(8'd200, 8'd10, 8'd10, 1'b0);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input int found,
                             input int xmn, input int xmx, input int ymn, input int ymx,
                             input int xc, input int yc);
        chk({tag, ".pix_count"}, 32'(pix_count), 32'(cnt));
        chk({tag, ".obj_found"}, 32'(obj_found), 32'(found));
        chk({tag, ".x_min"},     32'(x_min),     32'(xmn));
        chk({tag, ".x_max"},     32'(x_max),     32'(xmx));
        chk({tag, ".y_min"},     32'(y_min),     32'(ymn));
        chk({tag, ".y_max"},     32'(y_max),     32'(ymx));
        chk({tag, ".x_center"},  32'(x_center),  32'(xc));
        chk({tag, ".y_center"},  32'(y_center),  32'(yc));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        done_cnt = 0;
        pix_if.VGA_R = '0;
        pix_if.VGA_G = '0;
        pix_if.VGA_B = '0;
        pix_if.valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.frame_done", 32'(frame_done), 0);
        chk("reset.mask_valid", 32'(mask_valid), 0);
        reset_n = 1'b1;

        // Threshold edges
        drive(8'd160, 8'd80, 8'd80, 1'b1);
        drive(8'd159, 8'd80, 8'd80, 1'b1);
        chk("thr_160_80_80.mask", 32'(mask), 1);
        chk("thr_160_80_80.mask_valid", 32'(mask_valid), 1);
        drive(8'd160, 8'd81, 8'd80, 1'b1);
        chk("thr_159_80_80.mask", 32'(mask), 0);
        chk("thr_159_80_80.mask_valid", 32'(mask_valid), 1);
        drive(8'd160, 8'd80, 8'd81, 1'b1);
        chk("thr_160_81_80.mask", 32'(mask), 0);
        drive(8'd200, 8'd10, 8'd10, 1'b0);
        chk("thr_160_80_81.mask", 32'(mask), 0);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        chk("invalid_red.mask", 32'(mask), 0);
        chk("invalid_red.mask_valid", 32'(mask_valid), 0);

        // Partial red frame, then asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) drive(8'd200, 8'd10, 8'd10, 1'b1);
        drive(8'd200, 8'd10, 8'd10, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset.mask", 32'(mask), 0);
        chk("async_reset.mask_valid", 32'(mask_valid), 0);
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        reset_n = 1'b1;
        chk("async_reset.no_done", 32'(done_cnt), 0);

        // Single block frame
        send_frame(1, 1'b0, 0);
        chk("block.done_before_end", 32'(done_cnt), 0);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        chk("block.frame_done", 32'(frame_done), 1);
        check_all("block", 6, 1, 2, 4, 1, 2, 3, 1);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        chk("block.frame_done_drop", 32'(frame_done), 0);
        chk("block.done_cnt", 32'(done_cnt), 1);
        check_all("block_hold", 6, 1, 2, 4, 1, 2, 3, 1);

        // Below MIN_COUNT: box/centre hold
        send_frame(2, 1'b0, 0);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        chk("sparse.frame_done", 32'(frame_done), 1);
        check_all("sparse", 1, 0, 2, 4, 1, 2, 3, 1);

        // Valid gaps
        send_frame(1, 1'b1, 0);
        chk("gaps.done_before_end", 32'(done_cnt), 2);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        chk("gaps.frame_done", 32'(frame_done), 1);
        check_all("gaps", 6, 1, 2, 4, 1, 2, 3, 1);

        // Back-to-back frames: match at (7,3) then match at (0,0) of the next frame
        send_frame(3, 1'b0, 0);
        drive(8'd200, 8'd10, 8'd10, 1'b1);
        chk("b2b_a.frame_done", 32'(frame_done), 1);
        check_all("b2b_a", 7, 1, 2, 7, 1, 3, 4, 2);
        send_frame(0, 1'b0, 1);
        chk("b2b_b.done_before_end", 32'(done_cnt), 4);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        chk("b2b_b.frame_done", 32'(frame_done), 1);
        check_all("b2b_b", 1, 0, 2, 7, 1, 3, 4, 2);
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        chk("final.done_cnt", 32'(done_cnt), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
